// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter:
// shift modes and the per-stage sideband bundle.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SRA = 2'b00,
    SH_SRL = 2'b01,
    SH_SLL = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

  typedef struct packed {
    shift_mode_e mode;
    logic        round;
    logic        sat;
    logic        rbit;
    logic        ovf;
    logic        sign;
  } stage_sb_t;

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One registered log-shift stage: shifts by K when its
// shamt bit is set, tracking round bit and SLL overflow.
import shifter_pkg::*;

module shift_stage #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int K       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  stage_sb_t          in_sb,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output stage_sb_t          out_sb
);

  localparam int B = $clog2(K);

  logic               valid_d, valid_q;
  logic [WIDTH-1:0]   data_d, data_q;
  logic [SHAMT_W-1:0] shamt_d, shamt_q;
  stage_sb_t          sb_d, sb_q;

  logic [WIDTH-1:0] sra, srl, sll, ror, sll_back;
  logic             ovf_hit;

  assign sra      = WIDTH'($signed(in_data) >>> K);
  assign srl      = in_data >> K;
  assign sll      = in_data << K;
  assign ror      = (in_data >> K) | (in_data << (WIDTH - K));
  // top K+1 bits all equal iff shifting back recovers the input
  assign sll_back = WIDTH'($signed(sll) >>> K);
  assign ovf_hit  = (sll_back != in_data);

  always_comb begin
    valid_d = in_valid;
    data_d  = in_data;
    shamt_d = in_shamt;
    sb_d    = in_sb;
    if (in_shamt[B]) begin
      unique case (in_sb.mode)
        SH_SRA: begin
          data_d     = sra;
          sb_d.rbit  = in_data[K-1];
        end
        SH_SRL: data_d = srl;
        SH_SLL: begin
          data_d     = sll;
          sb_d.ovf   = in_sb.ovf | ovf_hit;
        end
        SH_ROR: data_d = ror;
        default: data_d = in_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      sb_q    <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      sb_q    <= sb_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_sb    = sb_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined log-barrel shifter (SRA/SRL/SLL/ROR) with rounding,
// saturation and a stalling valid/ready stream interface.
import shifter_pkg::*;

module pipelined_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic               in_round,
  input  logic               in_sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sat
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic               adv;
  logic               st_valid [SHAMT_W+1];
  logic [WIDTH-1:0]   st_data  [SHAMT_W+1];
  logic [SHAMT_W-1:0] st_shamt [SHAMT_W+1];
  stage_sb_t          st_sb    [SHAMT_W+1];

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic             out_sat_d, out_sat_q;

  logic             sra_rnd, sll_clamp;
  logic             unused_shamt;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign st_valid[0]       = in_valid;
  assign st_data[0]        = in_data;
  assign st_shamt[0]       = in_shamt;
  assign st_sb[0].mode     = shift_mode_e'(in_mode);
  assign st_sb[0].round    = in_round;
  assign st_sb[0].sat      = in_sat;
  assign st_sb[0].rbit     = 1'b0;
  assign st_sb[0].ovf      = 1'b0;
  assign st_sb[0].sign     = in_data[WIDTH-1];

  // largest shift first
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .K       (1 << (SHAMT_W - 1 - i))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (st_valid[i]),
      .in_data   (st_data[i]),
      .in_shamt  (st_shamt[i]),
      .in_sb     (st_sb[i]),
      .out_valid (st_valid[i+1]),
      .out_data  (st_data[i+1]),
      .out_shamt (st_shamt[i+1]),
      .out_sb    (st_sb[i+1])
    );
  end

  assign unused_shamt = ^st_shamt[SHAMT_W];

  assign sra_rnd   = (st_sb[SHAMT_W].mode == SH_SRA)
                  && st_sb[SHAMT_W].round;
  assign sll_clamp = (st_sb[SHAMT_W].mode == SH_SLL)
                  && st_sb[SHAMT_W].sat
                  && st_sb[SHAMT_W].ovf;

  always_comb begin
    out_valid_d = st_valid[SHAMT_W];
    out_data_d  = st_data[SHAMT_W];
    out_sat_d   = 1'b0;
    unique case (1'b1)
      sra_rnd: begin
        out_data_d = st_data[SHAMT_W]
                   + WIDTH'(st_sb[SHAMT_W].rbit);
      end
      sll_clamp: begin
        out_data_d = st_sb[SHAMT_W].sign ? SMIN : SMAX;
        out_sat_d  = 1'b1;
      end
      default: out_sat_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=16) against
// an arithmetic reference model and a FIFO scoreboard.
module tb_pipelined_shifter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic          in_round = 1'b0;
  logic          in_sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_sat;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [1:0]    m;
    logic          r;
    logic          sa;
    logic [W-1:0]  ed;
    logic          es;
    string         nm;
  } vec_t;

  vec_t tbl[$];

  pipelined_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_round  (in_round),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // result = {sat_flag, data}
  function automatic logic [W:0] model(
    input logic [W-1:0] d, input int s, input logic [1:0] m,
    input logic rnd, input logic sat);
    int     sv;
    int     uv;
    longint v;
    logic [W-1:0] r;
    logic   o;
    sv = int'($signed(d));
    uv = int'(d);
    o  = 1'b0;
    r  = d;
    case (m)
      2'd0: begin
        if (rnd && s > 0) r = W'((sv + (1 << (s - 1))) >>> s);
        else              r = W'(sv >>> s);
      end
      2'd1: r = W'(uv >> s);
      2'd2: begin
        v = longint'(sv) * (longint'(1) << s);
        if (sat && (v > 32767 || v < -32768)) begin
          o = 1'b1;
          r = (sv < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
          r = W'(v);
        end
      end
      default: r = W'((uv >> s) | (uv << (W - s)));
    endcase
    return {o, r};
  endfunction

  // scoreboard and protocol checker
  initial begin : compare
    logic [W:0]   e;
    logic         held_v;
    logic [W-1:0] held_d;
    logic         held_s;
    held_v = 1'b0;
    held_d = '0;
    held_s = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        held_v = 1'b0;
      end else begin
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
          errors++;
          $display("FAIL in_ready: got %b, expected %b",
                   in_ready, !out_valid || out_ready);
        end
        if (held_v) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== held_d
              || out_sat !== held_s) begin
            errors++;
            $display("FAIL hold: got v=%b d=%h s=%b, expected v=1 d=%h s=%b",
                     out_valid, out_data, out_sat, held_d, held_s);
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(in_data, int'(in_shamt), in_mode,
                                in_round, in_sat));
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious: got d=%h s=%b, expected no beat",
                     out_data, out_sat);
          end else begin
            e = exp_q.pop_front();
            if ({out_sat, out_data} !== e) begin
              errors++;
              $display("FAIL stream: got d=%h s=%b, expected d=%h s=%b",
                       out_data, out_sat, e[W-1:0], e[W]);
            end
          end
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
        held_s = out_sat;
      end
    end
  end

  task automatic add(input logic [W-1:0] d, input logic [SW-1:0] s,
                     input logic [1:0] m, input logic r, input logic sa,
                     input logic [W-1:0] ed, input logic es,
                     input string nm);
    vec_t x;
    x.d = d; x.s = s; x.m = m; x.r = r; x.sa = sa;
    x.ed = ed; x.es = es; x.nm = nm;
    tbl.push_back(x);
  endtask

  // single beat into an empty pipe; checks latency and value
  task automatic run_one(input vec_t x);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x.d;
    in_shamt  = x.s;
    in_mode   = x.m;
    in_round  = x.r;
    in_sat    = x.sa;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != 5 || out_data !== x.ed
        || out_sat !== x.es) begin
      errors++;
      $display("FAIL %s: got d=%h s=%b lat=%0d, expected d=%h s=%b lat=5",
               x.nm, out_data, out_sat, n, x.ed, x.es);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_beat();
    int pick;
    pick = int'($urandom_range(0, 7));
    case (pick)
      0: in_data = 16'h8000;
      1: in_data = 16'h7FFF;
      2: in_data = 16'hFFFF;
      3: in_data = 16'h0000;
      default: in_data = W'($urandom);
    endcase
    in_shamt = SW'($urandom);
    in_mode  = 2'($urandom);
    in_round = 1'($urandom);
    in_sat   = 1'($urandom);
  endtask

  initial begin : main
    logic [W:0] p;
    int         i;
    logic       acc;

    // reset state
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got v=%b d=%h s=%b rdy=%b, expected 0 0 0 1",
               out_valid, out_data, out_sat, in_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    add(16'h8000, 15, 2'd0, 0, 0, 16'hFFFF, 0, "sra_min_15");
    add(16'h7FFF,  8, 2'd0, 0, 0, 16'h007F, 0, "sra_max_8");
    add(16'h8000, 15, 2'd1, 0, 0, 16'h0001, 0, "srl_min_15");
    add(16'h0180,  8, 2'd0, 1, 0, 16'h0002, 0, "sra_rnd_up");
    add(16'hFE80,  8, 2'd0, 1, 0, 16'hFFFF, 0, "sra_rnd_neg");
    add(16'h017F,  8, 2'd0, 1, 0, 16'h0001, 0, "sra_rnd_dn");
    add(16'h0180,  8, 2'd1, 1, 0, 16'h0001, 0, "srl_rnd_ign");
    add(16'h4000,  1, 2'd2, 0, 1, 16'h7FFF, 1, "sll_sat_pos");
    add(16'hC000,  1, 2'd2, 0, 1, 16'h8000, 0, "sll_sat_fit");
    add(16'hA000,  1, 2'd2, 0, 1, 16'h8000, 1, "sll_sat_neg");
    add(16'h4000,  1, 2'd2, 0, 0, 16'h8000, 0, "sll_nosat");
    add(16'h0100,  8, 2'd2, 0, 1, 16'h7FFF, 1, "sll_sat_big");
    add(16'h4000,  1, 2'd1, 0, 1, 16'h2000, 0, "srl_sat_ign");
    add(16'h1234,  4, 2'd3, 0, 0, 16'h4123, 0, "ror_4");
    add(16'h8001,  0, 2'd0, 1, 1, 16'h8001, 0, "sh0_sra");
    add(16'h8001,  0, 2'd1, 1, 1, 16'h8001, 0, "sh0_srl");
    add(16'h8001,  0, 2'd2, 1, 1, 16'h8001, 0, "sh0_sll");
    add(16'h8001,  0, 2'd3, 1, 1, 16'h8001, 0, "sh0_ror");

    // pin the model, then the DUT, on hand-computed vectors
    foreach (tbl[k]) begin
      p = model(tbl[k].d, int'(tbl[k].s), tbl[k].m, tbl[k].r, tbl[k].sa);
      checks++;
      if (p !== {tbl[k].es, tbl[k].ed}) begin
        errors++;
        $display("FAIL model_%s: got d=%h s=%b, expected d=%h s=%b",
                 tbl[k].nm, p[W-1:0], p[W], tbl[k].ed, tbl[k].es);
      end
      run_one(tbl[k]);
    end

    // 10 back-to-back beats with a 3-cycle downstream stall
    i = 0;
    rand_beat();
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 8 && cyc <= 10);
      in_valid  = (i < 10);
      @(negedge clk);
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_%0d: got rdy=%b v=%b, expected rdy=0 v=1",
                   cyc, in_ready, out_valid);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        rand_beat();
      end
    end
    in_valid = 1'b0;
    checks++;
    if (i != 10 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_drain: got sent=%0d left=%0d v=%b, expected 10 0 0",
               i, exp_q.size(), out_valid);
    end

    // reset with beats in flight and one stalled at the output
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      rand_beat();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    i = 0;
    while (!out_valid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: got v=%b, expected v=1", out_valid);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: got v=%b d=%h rdy=%b, expected 0 0 1",
               out_valid, out_data, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_rst_%0d: got v=%b, expected v=0", c, out_valid);
      end
    end
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_beat();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: got left=%0d v=%b, expected 0 0",
               exp_q.size(), out_valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
